mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Two-port memory bus controller between the CPU core and the single shared memory.
- Port 0 carries instruction fetch; port 1 carries load/store data.
- Grants one requester at a time (round-robin or fixed priority) and registers the memory address, data and strobes.
- Waits for memory ready with a bounded timeout, then returns read data and a one-cycle acknowledge to the granted port.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
TIMEOUT_CYCLES, 16, max cycles spent in ACCESS waiting for mem_ready before an error completion (legal range 1..255)
FIXED_PRIORITY, 0, 0 = round-robin; 1 = port 1 always wins a simultaneous request

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
p0_req  input  1  port 0 request; held high until p0_ack or p0_err is seen
p0_write  input  1  port 0: 1 = write, 0 = read
p0_addr  input  ADDR_WIDTH  port 0 address
p0_wdata  input  DATA_WIDTH  port 0 write data
p0_rdata  output  DATA_WIDTH  port 0 read data, valid while p0_ack = 1
p0_ack  output  1  port 0 completion pulse, one cycle
p0_err  output  1  port 0 timeout completion pulse, one cycle
p1_req, p1_write, p1_addr, p1_wdata, p1_rdata, p1_ack, p1_err: same as port 0, for port 1
mem_address  output  ADDR_WIDTH  registered memory address
mem_data_out  output  DATA_WIDTH  registered write data to memory
mem_data_in  input  DATA_WIDTH  read data from memory, sampled when mem_ready = 1
mem_read  output  1  read strobe, high for the whole access
mem_write  output  1  write strobe, high for the whole access
mem_ready  input  1  memory completion, sampled only in ACCESS
busy  output  1  high when state is not IDLE
grant_id  output  1  port currently or most recently granted

Behaviour:
- Reset (synchronous, active-high), applied on the next rising edge, including mid-access:
  - state = IDLE, timeout counter = 0, priority pointer = port 0.
  - All outputs low or zero: strobes, acks, errs, rdata, mem_address, mem_data_out, busy, grant_id.
  - An in-flight access is abandoned with no ack or err.
- State machine IDLE -> ACCESS -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one req, grant that port.
  - If both req: with FIXED_PRIORITY = 1, port 1 wins. With round-robin, the pointer port wins.
  - On grant, latch that port's addr, wdata and write into mem_address, mem_data_out and mem_write/mem_read (exactly one high). Set grant_id, clear the counter, go to ACCESS.
- ACCESS:
  - Strobes held constant.
  - If mem_ready = 1 at the edge: capture mem_data_in into the granted port's rdata (reads only; writes leave rdata unchanged), drop both strobes, go to DONE with ack.
  - Else if counter == TIMEOUT_CYCLES-1: drop strobes, go to DONE with err, rdata unchanged.
  - Else increment the counter (8-bit, never wraps because of the range limit).
- DONE (exactly one cycle):
  - The granted port's ack or err is high; ack and err are never both high.
  - Round-robin pointer moves to the other port.
  - No new grant is taken in this cycle, so the requester drops req before IDLE resamples.
  - Next state is IDLE.
- Latency:
  - req sampled at edge N.
  - Strobes visible after edge N.
  - Earliest mem_ready sampled at edge N+1.
  - ack high in the cycle after edge N+1.
  - Minimum 3 cycles request-to-request per port, including the IDLE cycle.
- Request changes:
  - Changes to req, addr, wdata or write after grant are ignored until the next IDLE.
  - Dropping req mid-access does not cancel the access; ack/err still pulses.
- Outputs of the non-granted port:
  - ack and err stay 0.
  - rdata holds its last value.
- mem_ready outside ACCESS is ignored.

Test Plan:
- Single read: p0_req=1, p0_addr=0x0000_0010, mem_ready=1 one cycle after mem_read rises, mem_data_in=0xE3A0_1005 -> mem_address=0x10 and mem_read=1 for one cycle; p0_ack=1 for one cycle with p0_rdata=0xE3A0_1005; busy high 2 cycles.
- Single write with wait states: p1_req=1, p1_write=1, p1_addr=0x100, p1_wdata=0xCAFE_F00D, mem_ready held low 3 cycles then high -> mem_write=1 for 4 cycles with mem_data_out=0xCAFE_F00D; p1_ack pulse; p1_rdata unchanged.
- Round-robin contention: both req held continuously, instant mem_ready, FIXED_PRIORITY=0 -> grant_id sequence 0,1,0,1; each ack is a single pulse; no overlapping strobes.
- Fixed priority: FIXED_PRIORITY=1, both req high -> port 1 is served first, then port 0 once p1_req drops.
- Timeout: TIMEOUT_CYCLES=16, mem_ready tied 0, p0 read -> mem_read high exactly 16 cycles; p0_err=1 for one cycle; p0_ack=0; arbiter returns to IDLE and serves a following p1 request normally.
- Reset mid-access: assert reset on the second cycle of ACCESS -> after that edge, mem_read=0, busy=0, no ack/err ever pulses; a subsequent request from both ports grants port 0 first.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: instruction fetch (port 0) and load/store (port 1)
// share one memory through a registered IDLE -> ACCESS -> DONE handshake with timeout.
module mem_bus_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int FIXED_PRIORITY = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  p0_req,
   input  logic                  p0_write,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   output logic                  p0_ack,
   output logic                  p0_err,
   input  logic                  p1_req,
   input  logic                  p1_write,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic                  p1_ack,
   output logic                  p1_err,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data_out,
   input  logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_read,
   output logic                  mem_write,
   input  logic                  mem_ready,
   output logic                  busy,
   output logic                  grant_id
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

   state_t                state_q, state_d;
   logic [7:0]            count_q, count_d;
   logic                  ptr_q, ptr_d;
   logic                  grant_q, grant_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic                  busy_q, busy_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
   logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;
   logic                  p0_ack_q, p0_ack_d, p0_err_q, p0_err_d;
   logic                  p1_ack_q, p1_ack_d, p1_err_q, p1_err_d;
   logic                  pick;
   logic                  pick_write;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      busy_d      = busy_q;
      addr_d      = addr_q;
      dout_d      = dout_q;
      p0_rdata_d  = p0_rdata_q;
      p1_rdata_d  = p1_rdata_q;
      p0_ack_d    = 1'b0;
      p0_err_d    = 1'b0;
      p1_ack_d    = 1'b0;
      p1_err_d    = 1'b0;
      pick        = 1'b0;
      pick_write  = 1'b0;

      case (state_q)
         IDLE: begin
            if (p0_req || p1_req) begin
               // Contention goes to port 1 in fixed mode, otherwise to the pointer port
               if (p0_req && p1_req)
                  pick = (FIXED_PRIORITY != 0) ? 1'b1 : ptr_q;
               else
                  pick = p1_req;
               pick_write  = pick ? p1_write : p0_write;
               grant_d     = pick;
               addr_d      = pick ? p1_addr : p0_addr;
               dout_d      = pick ? p1_wdata : p0_wdata;
               mem_write_d = pick_write;
               mem_read_d  = !pick_write;
               count_d     = 8'd0;
               busy_d      = 1'b1;
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            if (mem_ready) begin
               if (mem_read_q) begin
                  if (grant_q) p1_rdata_d = mem_data_in;
                  else         p0_rdata_d = mem_data_in;
               end
               p0_ack_d    = !grant_q;
               p1_ack_d    = grant_q;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               state_d     = DONE;
            end else if (count_q == LAST_COUNT) begin
               p0_err_d    = !grant_q;
               p1_err_d    = grant_q;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               state_d     = DONE;
            end else begin
               count_d = count_q + 8'd1;
            end
         end
         DONE: begin
            ptr_d   = !grant_q;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= 8'd0;
         ptr_q       <= 1'b0;
         grant_q     <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         busy_q      <= 1'b0;
         addr_q      <= '0;
         dout_q      <= '0;
         p0_rdata_q  <= '0;
         p1_rdata_q  <= '0;
         p0_ack_q    <= 1'b0;
         p0_err_q    <= 1'b0;
         p1_ack_q    <= 1'b0;
         p1_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         busy_q      <= busy_d;
         addr_q      <= addr_d;
         dout_q      <= dout_d;
         p0_rdata_q  <= p0_rdata_d;
         p1_rdata_q  <= p1_rdata_d;
         p0_ack_q    <= p0_ack_d;
         p0_err_q    <= p0_err_d;
         p1_ack_q    <= p1_ack_d;
         p1_err_q    <= p1_err_d;
      end
   end

   assign p0_rdata     = p0_rdata_q;
   assign p0_ack       = p0_ack_q;
   assign p0_err       = p0_err_q;
   assign p1_rdata     = p1_rdata_q;
   assign p1_ack       = p1_ack_q;
   assign p1_err       = p1_err_q;
   assign mem_address  = addr_q;
   assign mem_data_out = dout_q;
   assign mem_read     = mem_read_q;
   assign mem_write    = mem_write_q;
   assign busy         = busy_q;
   assign grant_id     = grant_q;

endmodule
